// File: rtl/mesi_isc_arb_pkg.sv
// Shared types and constants for the broadcast-request arbiter.
package mesi_isc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam int unsigned MSG_TYPE_W = 2;

    localparam logic [MSG_TYPE_W-1:0] MSG_NOP      = 2'b00;
    localparam logic [MSG_TYPE_W-1:0] MSG_WR       = 2'b01;
    localparam logic [MSG_TYPE_W-1:0] MSG_RD       = 2'b10;
    localparam logic [MSG_TYPE_W-1:0] MSG_WR_BROAD = 2'b11;

    // The message type occupies the top MSG_TYPE_W bits of a request word.
    function automatic int unsigned msg_type_msb(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/mesi_isc_rr_picker.sv
// Combinational round-robin search: first requesting index after last_grant,
// wrapping modulo N_CPU (N_CPU is a power of two, so the index simply wraps).
module mesi_isc_rr_picker #(
    parameter int unsigned N_CPU        = 4,
    parameter int unsigned CPU_ID_WIDTH = 2
) (
    input  logic [N_CPU-1:0]        req,
    input  logic [CPU_ID_WIDTH-1:0] last_grant,
    output logic [CPU_ID_WIDTH-1:0] grant,
    output logic                    grant_vld
);

    logic [CPU_ID_WIDTH-1:0] idx;

    // Scan from lowest priority (last_grant itself) to highest (last_grant+1);
    // the final hit wins, so no early exit is needed.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N_CPU; i++) begin
            idx = last_grant + CPU_ID_WIDTH'(N_CPU - i);
            if (req[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_isc_breq_arb.sv
// Round-robin drain of the per-CPU broadcast-request FIFOs into the single
// broadcast FIFO; messages are tagged with the source CPU id, NOPs dropped.
module mesi_isc_breq_arb
    import mesi_isc_arb_pkg::*;
#(
    parameter int unsigned N_CPU        = 4,
    parameter int unsigned CPU_ID_WIDTH = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CPU-1:0]                   breq_empty_i,
    input  logic [N_CPU*DATA_WIDTH-1:0]        breq_data_i,
    output logic [N_CPU-1:0]                   breq_rd_o,
    input  logic                               bcast_full_i,
    output logic                               bcast_wr_o,
    output logic [CPU_ID_WIDTH+DATA_WIDTH-1:0] bcast_data_o,
    output logic                               busy_o,
    output logic [CNT_WIDTH-1:0]               fwd_cnt_o
);

    state_t                  state;
    logic [CPU_ID_WIDTH-1:0] sel;
    logic [CPU_ID_WIDTH-1:0] last_grant;
    logic [CPU_ID_WIDTH-1:0] src_q;
    logic [DATA_WIDTH-1:0]   hold;
    logic [MSG_TYPE_W-1:0]   hold_type;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [CPU_ID_WIDTH-1:0] pick;
    logic                    pick_vld;
    logic [CNT_WIDTH-1:0]    fwd_cnt;

    mesi_isc_rr_picker #(
        .N_CPU        (N_CPU),
        .CPU_ID_WIDTH (CPU_ID_WIDTH)
    ) u_picker (
        .req        (~breq_empty_i),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_vld  (pick_vld)
    );

    assign sel_data  = breq_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign hold_type = hold[msg_type_msb(DATA_WIDTH) -: MSG_TYPE_W];

    // bcast_data_o is the registered {src, hold} pair; both load only in CAP,
    // so the output is stable everywhere else.
    assign bcast_data_o = {src_q, hold};
    assign bcast_wr_o   = (state == WR) && !bcast_full_i && (hold_type != MSG_NOP);
    assign busy_o       = (state != IDLE);
    assign fwd_cnt_o    = fwd_cnt;

    // Read strobe decoded from registered state and selection only.
    always_comb begin
        breq_rd_o = '0;
        if (state == RD) begin
            breq_rd_o[sel] = 1'b1;
        end
    end

    // Arbitration FSM: select, pop, capture, then write (or drop a NOP).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= CPU_ID_WIDTH'(N_CPU - 1);
            src_q      <= '0;
            hold       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        sel        <= pick;
                        last_grant <= pick;
                        state      <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    hold  <= sel_data;
                    src_q <= sel;
                    state <= WR;
                end
                WR: begin
                    if (hold_type == MSG_NOP || !bcast_full_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of messages written to the broadcast FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_cnt <= '0;
        end else if (bcast_wr_o && (fwd_cnt != '1)) begin
            fwd_cnt <= fwd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mesi_isc_breq_arb.sv
// Scoreboard bench for mesi_isc_breq_arb: directed stimulus pushes expected
// grants/writes into queues, an independent negedge monitor checks them.
module tb_mesi_isc_breq_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      breq_empty_i;
    logic [N*DW-1:0]   breq_data_i;
    logic [N-1:0]      breq_rd_o;
    logic              bcast_full_i;
    logic              bcast_wr_o;
    logic [W+DW-1:0]   bcast_data_o;
    logic              busy_o;
    logic [CW-1:0]     fwd_cnt_o;

    mesi_isc_breq_arb #(
        .N_CPU        (N),
        .CPU_ID_WIDTH (W),
        .DATA_WIDTH   (DW),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .breq_empty_i (breq_empty_i),
        .breq_data_i  (breq_data_i),
        .breq_rd_o    (breq_rd_o),
        .bcast_full_i (bcast_full_i),
        .bcast_wr_o   (bcast_wr_o),
        .bcast_data_o (bcast_data_o),
        .busy_o       (busy_o),
        .fwd_cnt_o    (fwd_cnt_o)
    );

    int              n_chk  = 0;
    int              n_fail = 0;
    int              cyc    = 0;
    logic [DW-1:0]   fq [N][$];
    logic [DW-1:0]   fdata [N];
    int              exp_gnt [$];
    logic [W+DW-1:0] exp_wr [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Request FIFO model: data appears the cycle after rd_i, empty tracks contents.
    always_comb begin
        breq_data_i = '0;
        for (int k = 0; k < N; k++) breq_data_i[k*DW +: DW] = fdata[k];
    end

    initial begin
        logic [N-1:0] rdv;
        breq_empty_i = '1;
        for (int k = 0; k < N; k++) fdata[k] = '0;
        forever begin
            @(negedge clk);
            rdv = breq_rd_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++)
                if (rdv[k] && fq[k].size() > 0) fdata[k] = fq[k].pop_front();
            #2;
            for (int k = 0; k < N; k++) breq_empty_i[k] = (fq[k].size() == 0);
        end
    end

    // Monitor: every read strobe and every write is checked against the queues.
    initial forever begin
        int g;
        logic [W+DW-1:0] e;
        @(negedge clk);
        if (rst) begin
            if (breq_rd_o != '0) begin
                check("rd_onehot", 64'($onehot(breq_rd_o)), 64'd1);
                check("rd_not_empty", 64'(breq_rd_o & breq_empty_i), 64'd0);
                if (exp_gnt.size() == 0) check("rd_unexpected", 64'(breq_rd_o), 64'd0);
                else begin
                    g = exp_gnt.pop_front();
                    check("rd_grant", 64'(breq_rd_o), 64'(1) << g);
                end
            end
            if (bcast_wr_o) begin
                check("wr_while_full", 64'(bcast_full_i), 64'd0);
                check("rd_wr_overlap", 64'(breq_rd_o), 64'd0);
                if (exp_wr.size() == 0) check("wr_unexpected", 64'(bcast_data_o), 64'd0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_data", 64'(bcast_data_o), 64'(e));
                end
            end
        end
    end

    task automatic push(input int k, input logic [DW-1:0] msg);
        fq[k].push_back(msg);
    endtask

    task automatic expect_msg(input int k, input logic [DW-1:0] msg);
        exp_gnt.push_back(k);
        if (msg[DW-1 -: 2] != 2'b00) exp_wr.push_back({W'(k), msg});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (!(exp_gnt.size() == 0 && exp_wr.size() == 0 && !busy_o) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 64'(exp_gnt.size() == 0 && exp_wr.size() == 0 && !busy_o), 64'd1);
    endtask

    initial begin
        int c0, prev, n;
        logic [W+DW-1:0] d0;
        rst = 1'b0;
        bcast_full_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle with all FIFOs empty.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy_o), 64'd0);
            check("idle_rd", 64'(breq_rd_o), 64'd0);
            check("idle_wr", 64'(bcast_wr_o), 64'd0);
            check("idle_data", 64'(bcast_data_o), 64'd0);
            check("idle_cnt", 64'(fwd_cnt_o), 64'd0);
        end

        // Single request from CPU2.
        @(posedge clk); #2;
        expect_msg(2, 32'h4000_0010);
        push(2, 32'h4000_0010);
        @(negedge clk); check("b_T_rd", 64'(breq_rd_o), 64'd0);
        @(negedge clk); check("b_T1_rd", 64'(breq_rd_o), 64'b0100);
        @(negedge clk); check("b_T2_wr", 64'(bcast_wr_o), 64'd0);
        @(negedge clk); check("b_T3_wr", 64'(bcast_wr_o), 64'd1);
        check("b_T3_data", 64'(bcast_data_o), {30'd0, 2'd2, 32'h4000_0010});
        @(negedge clk); check("b_cnt", 64'(fwd_cnt_o), 64'd1);
        check("b_busy", 64'(busy_o), 64'd0);

        // All four FIFOs loaded after reset: order 0,1,2,3, writes 4 cycles apart.
        do_reset();
        @(posedge clk); #2;
        c0 = cyc;
        expect_msg(0, 32'h4000_1000); push(0, 32'h4000_1000);
        expect_msg(1, 32'h8000_1001); push(1, 32'h8000_1001);
        expect_msg(2, 32'hC000_1002); push(2, 32'hC000_1002);
        expect_msg(3, 32'h4000_1003); push(3, 32'h4000_1003);
        prev = 0;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!bcast_wr_o && n < 20);
            check("c_wr_seen", 64'(bcast_wr_o), 64'd1);
            if (w == 0) check("c_latency", 64'(cyc - c0), 64'd3);
            else        check("c_spacing", 64'(cyc - prev), 64'd4);
            prev = cyc;
        end
        drain(20);
        check("c_cnt", 64'(fwd_cnt_o), 64'd4);

        // NOP from CPU1 is dropped; CPU2 gets the next grant.
        @(posedge clk); #2;
        expect_msg(1, 32'h0000_0ABC); push(1, 32'h0000_0ABC);
        expect_msg(2, 32'h8000_0222); push(2, 32'h8000_0222);
        @(negedge clk);
        @(negedge clk); check("d_rd_nop", 64'(breq_rd_o), 64'b0010);
        @(negedge clk);
        @(negedge clk); check("d_nop_wr", 64'(bcast_wr_o), 64'd0);
        check("d_nop_cnt", 64'(fwd_cnt_o), 64'd4);
        @(negedge clk);
        @(negedge clk); check("d_next_rd", 64'(breq_rd_o), 64'b0100);
        drain(20);
        check("d_cnt", 64'(fwd_cnt_o), 64'd5);

        // Back-pressure: full for 5 cycles in WR, write on first not-full cycle.
        @(posedge clk); #2;
        bcast_full_i = 1'b1;
        expect_msg(3, 32'hC000_0333); push(3, 32'hC000_0333);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("e_full_wr", 64'(bcast_wr_o), 64'd0);
            check("e_full_data", 64'(bcast_data_o), {30'd0, 2'd3, 32'hC000_0333});
            check("e_full_busy", 64'(busy_o), 64'd1);
        end
        @(posedge clk); #2;
        bcast_full_i = 1'b0;
        @(negedge clk); check("e_release_wr", 64'(bcast_wr_o), 64'd1);
        @(negedge clk); check("e_cnt", 64'(fwd_cnt_o), 64'd6);

        // Asynchronous reset while stalled in WR drops the message.
        @(posedge clk); #2;
        bcast_full_i = 1'b1;
        exp_gnt.push_back(0);
        push(0, 32'h4000_0F0F);
        repeat (4) @(negedge clk);
        check("f_stalled_busy", 64'(busy_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("f_rst_busy", 64'(busy_o), 64'd0);
        check("f_rst_wr", 64'(bcast_wr_o), 64'd0);
        check("f_rst_data", 64'(bcast_data_o), 64'd0);
        check("f_rst_cnt", 64'(fwd_cnt_o), 64'd0);
        @(posedge clk); #2;
        bcast_full_i = 1'b0;
        #1 check("f_rst_wr2", 64'(bcast_wr_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("f_after_busy", 64'(busy_o), 64'd0);
        check("f_after_cnt", 64'(fwd_cnt_o), 64'd0);

        // Counter saturation: 17 forwards into a 4-bit counter.
        @(posedge clk); #2;
        d0 = '0;
        for (int i = 0; i < 17; i++) begin
            expect_msg(1, 32'h8000_0000 + 32'(i));
            push(1, 32'h8000_0000 + 32'(i));
        end
        drain(17 * 4 + 20);
        check("g_cnt_sat", 64'(fwd_cnt_o), 64'hF);
        check("g_last_data", 64'(bcast_data_o), {30'd0, 2'd1, 32'h8000_0010});

        check("end_gnt_q", 64'(exp_gnt.size()), 64'd0);
        check("end_wr_q", 64'(exp_wr.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
